// File: rtl/index_pkg.sv
// Shared index-bus definitions: width derivation, serializer state codes and
// the modular increment used wherever consecutive index slices are checked.
package index_pkg;

   localparam int SIZE_DEF = 16;
   localparam int K_DEF    = 4;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // SIZE is a power of two, so masking is the modulo
   function automatic logic [31:0] wrap_inc(input logic [31:0] idx,
                                            input logic [31:0] n,
                                            input logic [31:0] size);
      return (idx + n) & (size - 32'd1);
   endfunction

endpackage

// File: rtl/window_serializer_seq_checker.sv
// Flags a packed word whose slices are not base, base+1, ... modulo SIZE.
module seq_checker
   import index_pkg::*;
#(
   parameter  int SIZE = SIZE_DEF,
   parameter  int K    = K_DEF,
   localparam int IW   = idx_width(SIZE)
) (
   input  logic [IW*K-1:0] in_data,
   output logic            err
);

   logic [K-1:0] bad;

   assign bad[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < K; gi++) begin : g_slice
         assign bad[gi] = (32'(in_data[IW*(gi+1)-1 -: IW]) !=
                           wrap_inc(32'(in_data[IW-1:0]), 32'(gi), 32'(SIZE)));
      end
   endgenerate

   assign err = |bad;

endmodule

// File: rtl/window_serializer.sv
// Accepts a packed word of K consecutive indices and replays it one index per
// beat on a valid/ready stream, counting words that break the sequence.
module window_serializer
   import index_pkg::*;
#(
   parameter  int SIZE = SIZE_DEF,
   parameter  int K    = K_DEF,
   localparam int IW   = idx_width(SIZE),
   localparam int CW   = idx_width(K)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IW*K-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [IW-1:0]   out_data,
   output logic [CW-1:0]   out_idx,
   output logic            out_last,
   output logic            seq_err,
   output logic [7:0]      err_cnt
);

   logic [0:0]      state_reg;
   logic [IW*K-1:0] word_reg;
   logic [CW-1:0]   beat_reg;
   logic            seq_err_reg;
   logic [7:0]      err_cnt_reg;
   logic            chk_err;
   logic            accept;
   logic            beat_last;
   logic [IW-1:0]   slices [K];

   genvar gi;
   generate
      for (gi = 0; gi < K; gi++) begin : g_unpack
         assign slices[gi] = word_reg[IW*(gi+1)-1 -: IW];
      end
   endgenerate

   seq_checker #(.SIZE(SIZE), .K(K)) u_seq_checker (
      .in_data (in_data),
      .err     (chk_err)
   );

   assign beat_last = (beat_reg == CW'(K-1));
   assign out_valid = (state_reg == ST_SEND);
   assign out_data  = out_valid ? slices[beat_reg] : '0;
   assign out_idx   = beat_reg;
   assign out_last  = out_valid & beat_last;
   // Ready on the last beat lets the next word follow with no bubble
   assign in_ready  = rst_n & ((state_reg == ST_IDLE) | (out_valid & out_ready & out_last));
   assign accept    = in_valid & in_ready;
   assign seq_err   = seq_err_reg;
   assign err_cnt   = err_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         word_reg    <= '0;
         beat_reg    <= '0;
         seq_err_reg <= 1'b0;
         err_cnt_reg <= 8'd0;
      end else begin
         seq_err_reg <= accept & chk_err;
         if (accept & chk_err & (err_cnt_reg != 8'hFF))
            err_cnt_reg <= err_cnt_reg + 8'd1;

         if (accept) begin
            word_reg  <= in_data;
            beat_reg  <= '0;
            state_reg <= ST_SEND;
         end else if (out_valid & out_ready) begin
            if (beat_last) begin
               state_reg <= ST_IDLE;
               beat_reg  <= '0;
            end else begin
               beat_reg <= beat_reg + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_window_serializer.sv
// Bench for window_serializer (SIZE=16, K=4): directed table, hand sequences
// for streaming/saturation/reset, and random traffic against a beat-queue model.
module tb_window_serializer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic [1:0]  out_idx;
   logic        out_last;
   logic        seq_err;
   logic [7:0]  err_cnt;

   window_serializer #(.SIZE(16), .K(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .seq_err   (seq_err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model: queue of beats still owed downstream, plus error bookkeeping
   typedef struct {
      int data;
      int idx;
      bit last;
   } beat_t;

   beat_t q[$];
   bit    exp_seq_err = 1'b0;
   int    exp_err_cnt = 0;

   typedef struct {
      bit          iv;
      logic [15:0] d;
      bit          ordy;
      bit          ov;
      int          data;
      int          idx;
      bit          last;
      bit          rdy;
      bit          serr;
      int          ecnt;
   } vec_t;

   vec_t tbl[22];

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic reset_model();
      q.delete();
      exp_seq_err = 1'b0;
      exp_err_cnt = 0;
   endtask

   // Drive one cycle's inputs, compare against the model, then advance the model
   task automatic cycle(input bit iv, input logic [15:0] d, input bit ordy);
      bit    exp_valid;
      bit    exp_ready;
      bit    acc;
      bit    bad;
      int    base;
      int    s;
      beat_t b;
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
      exp_valid = (q.size() > 0);
      exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
      chk("in_ready", int'(in_ready), int'(exp_ready));
      chk("out_valid", int'(out_valid), int'(exp_valid));
      if (exp_valid) begin
         chk("out_data", int'(out_data), q[0].data);
         chk("out_idx", int'(out_idx), q[0].idx);
         chk("out_last", int'(out_last), int'(q[0].last));
      end
      chk("seq_err", int'(seq_err), int'(exp_seq_err));
      chk("err_cnt", int'(err_cnt), exp_err_cnt);

      if (exp_valid && ordy) void'(q.pop_front());
      acc = iv && exp_ready;
      bad = 1'b0;
      if (acc) begin
         base = int'(d & 16'hF);
         for (int i = 0; i < 4; i++) begin
            s = int'((d >> (4 * i)) & 16'hF);
            if (s != (base + i) % 16) bad = 1'b1;
            b.data = s;
            b.idx  = i;
            b.last = (i == 3);
            q.push_back(b);
         end
      end
      exp_seq_err = acc && bad;
      if (acc && bad && exp_err_cnt < 255) exp_err_cnt++;
   endtask

   function automatic vec_t mk(bit iv, logic [15:0] d, bit ordy, bit ov, int data,
                               int idx, bit last, bit rdy, bit serr, int ecnt);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.ov = ov; v.data = data;
      v.idx = idx; v.last = last; v.rdy = rdy; v.serr = serr; v.ecnt = ecnt;
      return v;
   endfunction

   initial begin
      int          rdy_cnt;
      int          val_cnt;
      int          base;
      logic [15:0] d;

      // Base 5, wrap base 14, bad word 9765, then backpressure on beat 2
      tbl[0]  = mk(1, 16'h8765, 1, 0, 0, 0, 0, 1, 0, 0);
      tbl[1]  = mk(0, 16'h0000, 1, 1, 5, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 16'h0000, 1, 1, 6, 1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 16'h0000, 1, 1, 7, 2, 0, 0, 0, 0);
      tbl[4]  = mk(1, 16'h10FE, 1, 1, 8, 3, 1, 1, 0, 0);
      tbl[5]  = mk(0, 16'h0000, 1, 1, 14, 0, 0, 0, 0, 0);
      tbl[6]  = mk(0, 16'h0000, 1, 1, 15, 1, 0, 0, 0, 0);
      tbl[7]  = mk(0, 16'h0000, 1, 1, 0, 2, 0, 0, 0, 0);
      tbl[8]  = mk(1, 16'h9765, 1, 1, 1, 3, 1, 1, 0, 0);
      tbl[9]  = mk(0, 16'h0000, 1, 1, 5, 0, 0, 0, 1, 1);
      tbl[10] = mk(0, 16'h0000, 1, 1, 6, 1, 0, 0, 0, 1);
      tbl[11] = mk(0, 16'h0000, 1, 1, 7, 2, 0, 0, 0, 1);
      tbl[12] = mk(0, 16'h0000, 1, 1, 9, 3, 1, 1, 0, 1);
      tbl[13] = mk(1, 16'h8765, 1, 0, 0, 0, 0, 1, 0, 1);
      tbl[14] = mk(0, 16'h0000, 1, 1, 5, 0, 0, 0, 0, 1);
      tbl[15] = mk(0, 16'h0000, 1, 1, 6, 1, 0, 0, 0, 1);
      tbl[16] = mk(0, 16'h0000, 0, 1, 7, 2, 0, 0, 0, 1);
      tbl[17] = mk(0, 16'h0000, 0, 1, 7, 2, 0, 0, 0, 1);
      tbl[18] = mk(0, 16'h0000, 0, 1, 7, 2, 0, 0, 0, 1);
      tbl[19] = mk(0, 16'h0000, 1, 1, 7, 2, 0, 0, 0, 1);
      tbl[20] = mk(0, 16'h0000, 1, 1, 8, 3, 1, 1, 0, 1);
      tbl[21] = mk(0, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 1);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset held while inputs toggle
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         #1;
         chk("rst_in_ready", int'(in_ready), 0);
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out_data", int'(out_data), 0);
         chk("rst_out_idx", int'(out_idx), 0);
         chk("rst_out_last", int'(out_last), 0);
         chk("rst_seq_err", int'(seq_err), 0);
         chk("rst_err_cnt", int'(err_cnt), 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      reset_model();

      for (int i = 0; i < 22; i++) begin
         cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy);
         chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
         if (tbl[i].ov) begin
            chk($sformatf("tbl%0d_out_data", i), int'(out_data), tbl[i].data);
            chk($sformatf("tbl%0d_out_idx", i), int'(out_idx), tbl[i].idx);
            chk($sformatf("tbl%0d_out_last", i), int'(out_last), int'(tbl[i].last));
         end
         chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].rdy));
         chk($sformatf("tbl%0d_seq_err", i), int'(seq_err), int'(tbl[i].serr));
         chk($sformatf("tbl%0d_err_cnt", i), int'(err_cnt), tbl[i].ecnt);
      end

      // Back-to-back: two words, 8 beats in 8 cycles, ready only on last beats
      cycle(1, 16'h8765, 1);
      rdy_cnt = 0;
      val_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(i < 4, 16'h10FE, 1);
         rdy_cnt += int'(in_ready);
         val_cnt += int'(out_valid);
      end
      chk("b2b_beats", val_cnt, 8);
      chk("b2b_ready_cycles", rdy_cnt, 2);
      cycle(0, 16'h0000, 1);

      // Saturation: a continuous stream of non-consecutive words
      for (int i = 0; i < 1 + 4 * 256; i++) cycle(1, 16'h9765, 1);
      cycle(0, 16'h0000, 1);
      chk("err_cnt_sat", int'(err_cnt), 255);
      for (int i = 0; i < 4; i++) cycle(0, 16'h0000, 1);

      // Reset in the middle of a word, after beat 1
      cycle(1, 16'h8765, 1);
      cycle(0, 16'h0000, 1);
      cycle(0, 16'h0000, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_err_cnt", int'(err_cnt), 0);
      chk("midrst_out_idx", int'(out_idx), 0);
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 16'h0000, 1);
      cycle(1, 16'h10FE, 1);
      cycle(0, 16'h0000, 1);
      chk("postrst_idx", int'(out_idx), 0);
      chk("postrst_data", int'(out_data), 14);

      // Random traffic: mostly consecutive words, some garbage, random backpressure
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            base = int'($urandom_range(0, 15));
            d = '0;
            for (int j = 0; j < 4; j++) d = d | 16'(((base + j) % 16) << (4 * j));
         end else begin
            d = 16'($urandom);
         end
         cycle(1'($urandom_range(0, 1)), d, $urandom_range(0, 9) < 7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
